// File: rtl/trax_pkg.sv
// rtl/trax_pkg.sv - shared Trax move-link constants, tile codes and move field helpers
package trax_pkg;

   localparam int MOVE_W = 22;

   typedef enum logic [1:0] {
      EMPTY  = 2'b00,
      PLUS   = 2'b01,
      SLASH  = 2'b10,
      BSLASH = 2'b11
   } tile_e;

   localparam logic [7:0] COL_BASE  = 8'h40;
   localparam logic [7:0] CH_ZERO   = 8'h30;
   localparam logic [7:0] CH_PLUS   = 8'h2B;
   localparam logic [7:0] CH_SLASH  = 8'h2F;
   localparam logic [7:0] CH_BSLASH = 8'h5C;
   localparam logic [7:0] CH_NL     = 8'h0A;

   function automatic logic [1:0] move_tile(input logic [MOVE_W-1:0] m);
      return m[21:20];
   endfunction

   function automatic logic [9:0] move_col(input logic [MOVE_W-1:0] m);
      return m[19:10];
   endfunction

   function automatic logic [9:0] move_row(input logic [MOVE_W-1:0] m);
      return m[9:0];
   endfunction

   function automatic logic [7:0] tile_char(input logic [1:0] t);
      case (tile_e'(t))
         PLUS:    return CH_PLUS;
         SLASH:   return CH_SLASH;
         default: return CH_BSLASH;
      endcase
   endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// rtl/uart_tx_byte.sv - 8N1 byte serializer; returns to idle for one cycle after each stop bit
module uart_tx_byte #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       byte_valid,
   input  logic [7:0] byte_data,
   output logic       byte_ready,
   output logic       tx
);

   localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

   logic        active;
   logic [15:0] baud_cnt;
   logic [3:0]  bit_idx;
   logic [8:0]  shift;

   assign byte_ready = !active;

   // bit_idx 0 is the start bit, 1..8 data, 9 the stop bit
   always_ff @(posedge clk) begin
      if (reset) begin
         active   <= 1'b0;
         baud_cnt <= '0;
         bit_idx  <= '0;
         shift    <= '1;
         tx       <= 1'b1;
      end else if (!active) begin
         if (byte_valid) begin
            active   <= 1'b1;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shift    <= {1'b1, byte_data};
            tx       <= 1'b0;
         end
      end else if (baud_cnt == BAUD_LAST) begin
         baud_cnt <= '0;
         if (bit_idx == 4'd9) begin
            active <= 1'b0;
            tx     <= 1'b1;
         end else begin
            bit_idx <= bit_idx + 4'd1;
            tx      <= shift[0];
            shift   <= {1'b1, shift[8:1]};
         end
      end else begin
         baud_cnt <= baud_cnt + 16'd1;
      end
   end

endmodule

// File: rtl/trax_move_uart_tx.sv
// rtl/trax_move_uart_tx.sv - renders a 22-bit Trax move as ASCII notation on an 8N1 UART line
module trax_move_uart_tx
   import trax_pkg::*;
#(
   parameter int CLKS_PER_BIT = 434,
   parameter int MAX_COL_CHAR = 26
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              move_valid,
   input  logic [MOVE_W-1:0] move_data,
   output logic              move_ready,
   output logic              tx,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CHECK = 3'd1;
   localparam logic [2:0] S_CONV  = 3'd2;
   localparam logic [2:0] S_COL   = 3'd3;
   localparam logic [2:0] S_DIG   = 3'd4;
   localparam logic [2:0] S_TILE  = 3'd5;
   localparam logic [2:0] S_NL    = 3'd6;

   logic [2:0]        state;
   logic [MOVE_W-1:0] move_q;
   logic [1:0]        tile;
   logic [9:0]        col;
   logic [9:0]        row;
   logic [9:0]        work;
   logic [1:0]        place;
   logic [3:0]        digit;
   logic [3:0]        dig_buf [0:3];
   logic [2:0]        dig_cnt;
   logic [1:0]        dig_idx;
   logic              nl_sent;
   logic              bad;
   logic              finishing;
   logic              accept;
   logic              byte_valid;
   logic              byte_ready;
   logic              byte_fire;
   logic [7:0]        byte_data;

   function automatic logic [9:0] pow10(input logic [1:0] p);
      case (p)
         2'd0:    return 10'd1000;
         2'd1:    return 10'd100;
         default: return 10'd10;
      endcase
   endfunction

   assign tile = move_tile(move_q);
   assign col  = move_col(move_q);
   assign row  = move_row(move_q);
   assign bad  = (tile == EMPTY) || (col > 10'(MAX_COL_CHAR));

   // The cycle after the newline's stop bit behaves as IDLE so a held valid is taken there
   assign finishing  = (state == S_NL) && nl_sent && byte_ready;
   assign move_ready = (state == S_IDLE) || finishing;
   assign accept     = move_valid && move_ready;
   assign done       = finishing;
   assign busy       = (state != S_IDLE) && !finishing;
   assign err        = (state == S_CHECK) && bad;
   assign byte_fire  = byte_valid && byte_ready;

   always_comb begin
      byte_valid = 1'b0;
      byte_data  = CH_NL;
      case (state)
         S_COL: begin
            byte_valid = 1'b1;
            byte_data  = COL_BASE + {3'b000, col[4:0]};
         end
         S_DIG: begin
            byte_valid = 1'b1;
            byte_data  = CH_ZERO + {4'b0000, dig_buf[dig_idx]};
         end
         S_TILE: begin
            byte_valid = 1'b1;
            byte_data  = tile_char(tile);
         end
         S_NL: begin
            byte_valid = !nl_sent;
            byte_data  = CH_NL;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         move_q  <= '0;
         work    <= '0;
         place   <= '0;
         digit   <= '0;
         dig_cnt <= '0;
         dig_idx <= '0;
         nl_sent <= 1'b0;
         for (int i = 0; i < 4; i++) dig_buf[i] <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (accept) begin
                  move_q <= move_data;
                  state  <= S_CHECK;
               end
            end
            S_CHECK: begin
               if (bad) begin
                  state <= S_IDLE;
               end else begin
                  work    <= row;
                  place   <= '0;
                  digit   <= '0;
                  dig_cnt <= '0;
                  dig_idx <= '0;
                  state   <= S_CONV;
               end
            end
            // Leading zeros are dropped until the first non-zero digit; units always kept
            S_CONV: begin
               if (place == 2'd3) begin
                  dig_buf[dig_cnt[1:0]] <= work[3:0];
                  dig_cnt               <= dig_cnt + 3'd1;
                  state                 <= S_COL;
               end else if (work >= pow10(place)) begin
                  work  <= work - pow10(place);
                  digit <= digit + 4'd1;
               end else begin
                  if (digit != 4'd0 || dig_cnt != 3'd0) begin
                     dig_buf[dig_cnt[1:0]] <= digit;
                     dig_cnt               <= dig_cnt + 3'd1;
                  end
                  digit <= '0;
                  place <= place + 2'd1;
               end
            end
            S_COL: begin
               if (byte_fire) state <= S_DIG;
            end
            S_DIG: begin
               if (byte_fire) begin
                  if ({1'b0, dig_idx} == dig_cnt - 3'd1) state <= S_TILE;
                  else dig_idx <= dig_idx + 2'd1;
               end
            end
            S_TILE: begin
               if (byte_fire) begin
                  nl_sent <= 1'b0;
                  state   <= S_NL;
               end
            end
            S_NL: begin
               if (byte_fire) begin
                  nl_sent <= 1'b1;
               end else if (finishing) begin
                  if (accept) begin
                     move_q <= move_data;
                     state  <= S_CHECK;
                  end else begin
                     state <= S_IDLE;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   uart_tx_byte #(
      .CLKS_PER_BIT(CLKS_PER_BIT)
   ) u_byte (
      .clk        (clk),
      .reset      (reset),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .tx         (tx)
   );

endmodule

// File: tb/tb_trax_move_uart_tx.sv
// tb/tb_trax_move_uart_tx.sv - self-checking bench with a string-level model of the move line
module tb_trax_move_uart_tx;

   localparam int CPB   = 16;
   localparam int SLOT  = 10 * CPB + 1;
   localparam int LIMIT = 20000;

   localparam int M_IDLE   = 0;
   localparam int M_BAD    = 1;
   localparam int M_WAIT   = 2;
   localparam int M_STREAM = 3;
   localparam int M_DONE   = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        move_valid = 1'b0;
   logic [21:0] move_data = '0;
   logic        move_ready, tx, busy, done, err;

   int n_checks = 0;
   int n_fail   = 0;

   trax_move_uart_tx #(.CLKS_PER_BIT(CPB), .MAX_COL_CHAR(26)) dut (
      .clk        (clk),
      .reset      (reset),
      .move_valid (move_valid),
      .move_data  (move_data),
      .move_ready (move_ready),
      .tx         (tx),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   initial begin
      #(10 * 150000);
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_str(input string name, input string act, input string exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got len %0d \"%s\" expected len %0d \"%s\"", name, act.len(), act, exp.len(), exp);
      end
   endtask

   // Expected line text for a valid move, straight from the notation rules
   function automatic string model_str(input logic [21:0] m);
      logic [7:0] cc, tc;
      cc = 8'h40 + 8'(m[19:10]);
      case (m[21:20])
         2'b01:   tc = 8'h2B;
         2'b10:   tc = 8'h2F;
         default: tc = 8'h5C;
      endcase
      return $sformatf("%c%0d%c%c", cc, m[9:0], tc, 8'h0A);
   endfunction

   function automatic logic [21:0] mv(input int t, input int c, input int r);
      return {2'(t), 10'(c), 10'(r)};
   endfunction

   bit          exp_q[$];
   string       frames[$];
   string       cap;
   logic [7:0]  rxb;
   logic [21:0] cur;
   int          mode = M_IDLE;
   int          wait_cnt, c_pos, o;
   int          n_accept = 0;
   int          n_err_pulses = 0;
   logic        prev_reset = 1'b0;

   task automatic build_bits(input string s);
      logic [7:0] b;
      exp_q.delete();
      for (int i = 0; i < s.len(); i++) begin
         b = s.getc(i);
         repeat (CPB) exp_q.push_back(1'b0);
         for (int j = 0; j < 8; j++) repeat (CPB) exp_q.push_back(b[j]);
         repeat (CPB) exp_q.push_back(1'b1);
         if (i != s.len() - 1) exp_q.push_back(1'b1);
      end
   endtask

   always @(negedge clk) begin
      if (reset) begin
         if (prev_reset) begin
            chk("rst_tx", tx, 1);
            chk("rst_ready", move_ready, 1);
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_err", err, 0);
         end
         mode = M_IDLE;
         exp_q.delete();
      end else begin
         if (err) n_err_pulses++;
         if (mode == M_IDLE || mode == M_DONE) begin
            chk("idle_tx", tx, 1);
            chk("idle_ready", move_ready, 1);
            chk("idle_busy", busy, 0);
            chk("idle_err", err, 0);
            chk("done_pulse", done, (mode == M_DONE) ? 1 : 0);
            if (mode == M_DONE) frames.push_back(cap);
            mode = M_IDLE;
            if (move_valid) begin
               cur = move_data;
               n_accept++;
               if (cur[21:20] == 2'b00 || cur[19:10] > 10'd26) begin
                  mode = M_BAD;
               end else begin
                  build_bits(model_str(cur));
                  wait_cnt = 0;
                  cap = "";
                  mode = M_WAIT;
               end
            end
         end else if (mode == M_BAD) begin
            chk("bad_err", err, 1);
            chk("bad_tx", tx, 1);
            chk("bad_ready", move_ready, 0);
            chk("bad_done", done, 0);
            mode = M_IDLE;
         end else begin
            chk("frame_err", err, 0);
            chk("frame_done", done, 0);
            chk("frame_ready", move_ready, 0);
            chk("frame_busy", busy, 1);
            if (mode == M_WAIT) begin
               wait_cnt++;
               if (tx === 1'b0) begin
                  chk("start_within_45", (wait_cnt <= 45) ? 1 : 0, 1);
                  mode = M_STREAM;
                  c_pos = 0;
               end else if (wait_cnt > 45) begin
                  chk("start_latency", wait_cnt, 45);
                  mode = M_IDLE;
               end
            end
            if (mode == M_STREAM) begin
               chk("tx_bit", tx, exp_q.pop_front());
               o = c_pos % SLOT;
               if (o >= CPB && o < 9 * CPB && (o % CPB) == CPB / 2) rxb[(o / CPB) - 1] = tx;
               if (o == 9 * CPB + CPB / 2) cap = {cap, $sformatf("%c", rxb)};
               c_pos++;
               if (exp_q.size() == 0) mode = M_DONE;
            end
         end
      end
      prev_reset = reset;
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [21:0] m);
      int to;
      to = 0;
      while (!move_ready && to < LIMIT) begin tick(); to++; end
      move_valid = 1'b1;
      move_data  = m;
      tick();
      move_valid = 1'b0;
      move_data  = 22'($urandom);
   endtask

   task automatic wait_idle();
      int to;
      to = 0;
      while (!(move_ready && !busy) && to < LIMIT) begin tick(); to++; end
      chk("finish_in_time", (to < LIMIT) ? 1 : 0, 1);
      tick();
   endtask

   function automatic string last_frame();
      if (frames.size() == 0) return "";
      return frames[frames.size() - 1];
   endfunction

   initial begin
      int f0, e0, a0, to;
      logic [21:0] m;
      int rows [6] = '{9, 10, 99, 100, 999, 1000};

      chk_str("model_pin_z1023", model_str(mv(3, 26, 1023)), "Z1023\\\n");
      chk_str("model_pin_a1", model_str(mv(1, 1, 1)), "A1+\n");

      repeat (3) tick();
      reset = 1'b0;
      tick();

      // 1..3: basic frames
      f0 = frames.size();
      send(mv(1, 1, 1)); wait_idle();
      chk("t1_frames", frames.size(), f0 + 1);
      chk_str("t1_bytes", last_frame(), "A1+\n");
      send(mv(2, 0, 0)); wait_idle();
      chk_str("t2_bytes", last_frame(), "@0/\n");
      send(mv(3, 26, 1023)); wait_idle();
      chk_str("t3_bytes", last_frame(), "Z1023\\\n");
      chk("t3_frames", frames.size(), f0 + 3);

      // 4: rejected moves
      f0 = frames.size(); e0 = n_err_pulses;
      send(mv(0, 5, 5)); wait_idle();
      chk("t4_err_tile", n_err_pulses, e0 + 1);
      send(mv(1, 27, 5)); wait_idle();
      chk("t4_err_col", n_err_pulses, e0 + 2);
      chk("t4_no_frames", frames.size(), f0);

      // 5: valid held high across two moves
      f0 = frames.size(); a0 = n_accept;
      move_valid = 1'b1; move_data = mv(1, 4, 7);
      tick();
      move_data = mv(2, 8, 305);
      to = 0;
      while (frames.size() < f0 + 1 && to < LIMIT) begin tick(); to++; end
      move_valid = 1'b0;
      wait_idle();
      chk("t5_frames", frames.size(), f0 + 2);
      chk("t5_accepts", n_accept, a0 + 2);
      if (frames.size() >= 2) begin
         chk_str("t5_first", frames[frames.size() - 2], "D7+\n");
         chk_str("t5_second", frames[frames.size() - 1], "H305/\n");
      end

      // 6: reset during the third data bit of byte 2
      f0 = frames.size();
      send(mv(1, 2, 5));
      to = 0;
      while (tx !== 1'b0 && to < 60) begin tick(); to++; end
      chk("t6_start_seen", tx, 0);
      repeat (SLOT + 3 * CPB + CPB / 2) tick();
      chk("t6_mid_frame_busy", busy, 1);
      reset = 1'b1;
      tick();
      chk("t6_tx_after_reset", tx, 1);
      reset = 1'b0;
      repeat (5 * CPB) tick();
      chk("t6_no_done", frames.size(), f0);
      send(mv(1, 3, 12)); wait_idle();
      chk_str("t6_after", last_frame(), "C12+\n");

      // Row boundaries, then random moves checked by the model
      foreach (rows[i]) begin
         send(mv(1 + (i % 3), i * 5, rows[i])); wait_idle();
      end
      for (int k = 0; k < 14; k++) begin
         m[21:20] = ($urandom_range(0, 7) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
         m[19:10] = 10'($urandom_range(0, 28));
         m[9:0]   = 10'($urandom_range(0, 1023));
         send(m); wait_idle();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
